// File: rtl/magic_ctrl_pkg.sv
// Shared types and constants for the magic-mode controller and its config bank.
package magic_ctrl_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StPending,
      StMapped,
      StUnmap,
      StReenter
   } magic_state_t;

   localparam logic [7:0] MAGIC_CFG_STATUS_IDX = 8'h00;

   // Readback layout of the status byte: live status on top, cause below.
   function automatic logic [7:0] status_byte(input logic [3:0] live, input logic [3:0] cause_lo);
      return {live, cause_lo};
   endfunction

endpackage

// File: rtl/magic_ctrl_if.sv
// Z80 bus view seen by the magic controller: address/data, decoded strobes and readback.
interface magic_ctrl_if;

   logic [15:0] bus_a;
   logic [7:0]  bus_d;
   logic        bus_mreq;
   logic        bus_ioreq;
   logic        bus_m1;
   logic        bus_rd;
   logic        bus_wr;
   logic        bus_mreq_rise;
   logic [7:0]  d_out;
   logic        d_out_active;

   modport master (
      output bus_a, bus_d, bus_mreq, bus_ioreq, bus_m1, bus_rd, bus_wr, bus_mreq_rise,
      input  d_out, d_out_active
   );

   modport slave (
      input  bus_a, bus_d, bus_mreq, bus_ioreq, bus_m1, bus_rd, bus_wr, bus_mreq_rise,
      output d_out, d_out_active
   );

endinterface

// File: rtl/magic_ctrl_cfg_bank.sv
// Config byte bank for the magic controller: W1C cause register at index 0,
// plain bytes at 1..NREGS-1, and a registered readback mux.
module magic_cfg_bank
   import magic_ctrl_pkg::*;
#(
   parameter int unsigned           NREGS     = 16,
   parameter logic [NREGS*8-1:0]    CFG_RESET = '0,
   parameter int unsigned           NTRIG     = 2
) (
   input  logic               clk28,
   input  logic               rst,
   input  logic               cs_i,
   input  logic               wr_i,
   input  logic               rd_i,
   input  logic [7:0]         idx_i,
   input  logic [7:0]         wdata_i,
   input  logic [3:0]         status_i,
   input  logic               trig_set_i,
   input  logic [NTRIG-1:0]   trig_i,
   output logic [NTRIG-1:0]   cause_o,
   output logic [NREGS*8-1:0] cfg_o,
   output logic [7:0]         rdata_o,
   output logic               rdata_active_o
);

   localparam int unsigned IdxW = $clog2(NREGS);

   logic [NREGS-1:1][7:0] regs_q, regs_d;
   logic [NTRIG-1:0]      cause_q, cause_d;
   logic [7:0]            rdata_q, rdata_d;
   logic                  rdata_active_q, rdata_active_d;
   logic [7:0]            cause8;
   logic [7:0]            rd_mux;

   assign cause8 = 8'(cause_q);

   always_comb begin
      regs_d         = regs_q;
      cause_d        = cause_q;
      rdata_d        = rdata_q;
      rdata_active_d = cs_i & rd_i;
      rd_mux         = 8'hFF;

      if (cs_i && wr_i) begin
         if (idx_i == MAGIC_CFG_STATUS_IDX) begin
            cause_d = cause_q & ~wdata_i[NTRIG-1:0];
         end
         for (int i = 1; i < NREGS; i++) begin
            if (idx_i == 8'(i)) regs_d[IdxW'(i)] = wdata_i;
         end
      end
      // A trigger only fires outside magic mode, so it overrides any W1C on the same clock.
      if (trig_set_i) cause_d = trig_i;

      if (idx_i == MAGIC_CFG_STATUS_IDX) rd_mux = status_byte(status_i, cause8[3:0]);
      for (int i = 1; i < NREGS; i++) begin
         if (idx_i == 8'(i)) rd_mux = regs_q[IdxW'(i)];
      end
      if (cs_i && rd_i) rdata_d = rd_mux;
   end

   always_ff @(posedge clk28 or posedge rst) begin
      if (rst) begin
         regs_q         <= CFG_RESET[NREGS*8-1:8];
         cause_q        <= '0;
         rdata_q        <= '0;
         rdata_active_q <= 1'b0;
      end else begin
         regs_q         <= regs_d;
         cause_q        <= cause_d;
         rdata_q        <= rdata_d;
         rdata_active_q <= rdata_active_d;
      end
   end

   assign cause_o        = cause_q;
   assign cfg_o          = {regs_q, cause8};
   assign rdata_o        = rdata_q;
   assign rdata_active_o = rdata_active_q;

endmodule

// File: rtl/magic_ctrl.sv
// Magic-mode controller: NMI entry on frame-synchronised triggers, magic ROM mapping with a
// signature check, exit/re-entry decode and a config bank readable over the magic I/O port.
module magic_ctrl
   import magic_ctrl_pkg::*;
#(
   parameter int unsigned           NTRIG          = 2,
   parameter int unsigned           SIG_LEN        = 2,
   parameter logic [7:0]            SIG_BYTE       = 8'hEB,
   parameter logic [15:0]           NMI_ADDR       = 16'h0066,
   parameter logic [15:0]           EXIT_ADDR      = 16'hF000,
   parameter logic [15:0]           REENTER_ADDR   = 16'hF008,
   parameter logic [7:0]            CFG_PORT       = 8'hFF,
   parameter int unsigned           NREGS          = 16,
   parameter logic [NREGS*8-1:0]    CFG_RESET      = '0,
   parameter bit                    MAGIC_ON_START = 1'b1
) (
   input  logic               clk28,
   input  logic               rst,
   magic_ctrl_if.slave        bus,
   input  logic               n_int,
   input  logic               n_int_next,
   input  logic [NTRIG-1:0]   trig,
   input  logic [3:0]         status_in,
   output logic               n_nmi,
   output logic               magic_mode,
   output logic               magic_map,
   output logic [NTRIG-1:0]   cause,
   output logic [NREGS*8-1:0] cfg
);

   localparam int unsigned   SigW    = (SIG_LEN > 0) ? $clog2(SIG_LEN + 1) : 1;
   localparam logic [SigW-1:0] SigInit = SigW'(SIG_LEN);

   magic_state_t    state_q, state_d;
   logic            n_nmi_q, n_nmi_d;
   logic            mode_q, mode_d;
   logic            map_q, map_d;
   logic            reenter_q, reenter_d;
   logic            fetch_q, fetch_d;
   logic            match_q, match_d;
   logic [SigW-1:0] sig_q, sig_d;

   logic fe, fetch, m1_rise, rd_cycle, trig_fire, cfg_cs;

   assign fe        = n_int & ~n_int_next;
   assign fetch     = bus.bus_m1 & bus.bus_mreq & bus.bus_rd;
   assign m1_rise   = bus.bus_m1 & bus.bus_mreq_rise;
   assign rd_cycle  = bus.bus_mreq & bus.bus_rd;
   assign trig_fire = fe & (|trig) & ~mode_q & (state_q == StIdle);
   assign cfg_cs    = map_q & bus.bus_ioreq & (bus.bus_a[7:0] == CFG_PORT);

   always_comb begin
      state_d   = state_q;
      n_nmi_d   = n_nmi_q;
      mode_d    = mode_q;
      map_d     = map_q;
      reenter_d = reenter_q;
      sig_d     = sig_q;
      fetch_d   = fetch;
      // Opcode comparison is latched during the fetch and judged when the strobe ends.
      match_d   = fetch ? (bus.bus_d == SIG_BYTE) : match_q;

      unique case (state_q)
         StIdle: begin
            if (trig_fire) begin
               n_nmi_d = 1'b0;
               mode_d  = 1'b1;
               state_d = StPending;
            end
         end
         StPending: begin
            if (m1_rise && bus.bus_a == NMI_ADDR) begin
               map_d   = 1'b1;
               n_nmi_d = 1'b1;
               sig_d   = SigInit;
               state_d = StMapped;
            end
         end
         StMapped: begin
            if (sig_q != '0) begin
               if (fetch_q && !fetch) begin
                  if (match_q) begin
                     sig_d = sig_q - SigW'(1);
                  end else begin
                     mode_d  = 1'b0;
                     map_d   = 1'b0;
                     sig_d   = '0;
                     state_d = StIdle;
                  end
               end
            end else if (rd_cycle && bus.bus_a == EXIT_ADDR) begin
               mode_d    = 1'b0;
               reenter_d = 1'b0;
               state_d   = StUnmap;
            end else if (rd_cycle && bus.bus_a == REENTER_ADDR) begin
               reenter_d = 1'b1;
               state_d   = StUnmap;
            end
         end
         StUnmap: begin
            // Hold the ROM mapped until the exit read itself has completed.
            if (!bus.bus_mreq) begin
               map_d   = 1'b0;
               state_d = reenter_q ? StReenter : StIdle;
            end
         end
         StReenter: begin
            if (m1_rise) begin
               map_d   = 1'b1;
               state_d = StMapped;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk28 or posedge rst) begin
      if (rst) begin
         state_q   <= MAGIC_ON_START ? StMapped : StIdle;
         n_nmi_q   <= 1'b1;
         mode_q    <= MAGIC_ON_START;
         map_q     <= MAGIC_ON_START;
         reenter_q <= 1'b0;
         sig_q     <= MAGIC_ON_START ? SigInit : '0;
         fetch_q   <= 1'b0;
         match_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         n_nmi_q   <= n_nmi_d;
         mode_q    <= mode_d;
         map_q     <= map_d;
         reenter_q <= reenter_d;
         sig_q     <= sig_d;
         fetch_q   <= fetch_d;
         match_q   <= match_d;
      end
   end

   assign n_nmi      = n_nmi_q;
   assign magic_mode = mode_q;
   assign magic_map  = map_q;

   magic_cfg_bank #(
      .NREGS     (NREGS),
      .CFG_RESET (CFG_RESET),
      .NTRIG     (NTRIG)
   ) u_cfg_bank (
      .clk28          (clk28),
      .rst            (rst),
      .cs_i           (cfg_cs),
      .wr_i           (bus.bus_wr),
      .rd_i           (bus.bus_rd),
      .idx_i          (bus.bus_a[15:8]),
      .wdata_i        (bus.bus_d),
      .status_i       (status_in),
      .trig_set_i     (trig_fire),
      .trig_i         (trig),
      .cause_o        (cause),
      .cfg_o          (cfg),
      .rdata_o        (bus.d_out),
      .rdata_active_o (bus.d_out_active)
   );

endmodule
